// File: rtl/fdiv_seq.sv
// Sequential single-precision divider: one restoring quotient bit per cycle,
// fixed 26-cycle latency, truncated mantissa, denormals flushed to zero.
module fdiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        quo_q, quo_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [31:0]        y_q, y_d;

  logic [23:0]        m1, m2;
  logic               rem_ge;
  logic [25:0]        rem_step;
  logic [23:0]        quo_next;
  logic               sy, z1, z2;
  logic [31:0]        result;

  assign m1       = {1'b1, a_q[22:0]};
  assign m2       = {1'b1, b_q[22:0]};
  assign rem_ge   = rem_q >= {2'b00, m2};
  assign rem_step = rem_ge ? (rem_q - {2'b00, m2}) : rem_q;
  assign quo_next = (quo_q << 1) | {23'b0, rem_ge};

  assign sy = a_q[31] ^ b_q[31];
  assign z1 = (a_q[30:23] == 8'h00);
  assign z2 = (b_q[30:23] == 8'h00);

  // Result is formed from the final quotient bit so y is already new in DONE.
  always_comb begin
    result = {sy, exp_q[7:0], quo_next[22:0]};
    if (z1 && z2)
      result = 32'h7FC0_0000;
    else if (z2)
      result = {sy, 8'hFF, 23'h0};
    else if (z1)
      result = {sy, 31'h0};
    else if (exp_q >= 10'sd255)
      result = {sy, 8'hFF, 23'h0};
    else if (exp_q <= 10'sd0)
      result = {sy, 31'h0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = x1;
          b_d     = x2;
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d = 5'd0;
        quo_d = 24'd0;
        if (m1 >= m2) begin
          rem_d = {2'b00, m1};
          exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        end else begin
          rem_d = {1'b0, m1, 1'b0};
          exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd126;
        end
        state_d = DIV;
      end
      DIV: begin
        rem_d = rem_step << 1;
        quo_d = quo_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          y_d     = result;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      rem_q   <= 26'h0;
      quo_q   <= 24'h0;
      exp_q   <= 10'sd0;
      y_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
    end
  end

  assign y     = y_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: directed cases plus random operands checked against an
// arithmetic reference of the divide rules.
`timescale 1ns/1ps
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x1 = 32'h0;
  logic [31:0] x2 = 32'h0;
  logic [31:0] y;
  logic        valid;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_y = 32'h0;

  fdiv_seq dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .x1    (x1),
    .x2    (x2),
    .y     (y),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quotient as a real number, truncated to 24 significant bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic          s;
    int            ea, eb, e;
    longint        ma, mb, q;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ea == 0 && eb == 0) return 32'h7FC00000;
    if (eb == 0) return {s, 8'hFF, 23'h0};
    if (ea == 0) return {s, 31'h0};
    if (ma >= mb) begin
      q = (ma << 23) / mb;
      e = ea - eb + 127;
    end else begin
      q = (ma << 24) / mb;
      e = ea - eb + 126;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0)
      r[30:23] = 8'h00;
    else if (sel == 1)
      r[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(1, 15));
    else
      r[30:23] = 8'($urandom_range(90, 165));
    return r;
  endfunction

  // Start in cycle 0, observe cycles 1..27; optional ignored start at cycle intr.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int intr, input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] seen_y;
    @(negedge clk);
    x1 = a; x2 = b; start = 1'b1;
    seen_y = 32'h0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      chk($sformatf("busy c%0d", k), {31'b0, busy}, {31'b0, (k <= 26)});
      chk($sformatf("valid c%0d", k), {31'b0, valid}, {31'b0, (k == 26)});
      chk($sformatf("y c%0d", k), y, (k < 26) ? last_y : exp);
      if (k == 26) seen_y = y;
      if (k == intr) begin
        start = 1'b1; x1 = ia; x2 = ib;
      end else begin
        start = 1'b0; x1 = $urandom; x2 = $urandom;
      end
    end
    last_y = exp;
    $display("op x1=%h x2=%h y=%h expected=%h", a, b, seen_y, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset y", y, 32'h0);
    chk("reset valid", {31'b0, valid}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    rstn = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 32'h0, 32'h0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 32'h0, 32'h0);
    run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 0, 32'h0, 32'h0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 0, 32'h0, 32'h0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 0, 32'h0, 32'h0);
    run_op(32'h80000000, 32'h40A00000, 32'h80000000, 0, 32'h0, 32'h0);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 0, 32'h0, 32'h0);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 0, 32'h0, 32'h0);
    run_op(32'h3F800000, 32'h80000000, 32'hFF800000, 0, 32'h0, 32'h0);
    run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 32'h0, 32'h0);

    // Start during busy is ignored and operands stay latched.
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5, 32'h3F800000, 32'h40400000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle after ignored start", {31'b0, busy}, 32'h0);
    end

    // Abort with reset at cycle 10; start while in reset is ignored.
    @(negedge clk);
    x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 11) begin
        chk($sformatf("abort busy c%0d", k), {31'b0, busy}, 32'h0);
        chk($sformatf("abort y c%0d", k), y, 32'h0);
      end
      chk($sformatf("abort valid c%0d", k), {31'b0, valid}, 32'h0);
      if (k == 10) begin
        rstn = 1'b0; start = 1'b1; x1 = 32'h3F800000; x2 = 32'h40400000;
      end else begin
        rstn = 1'b1; start = 1'b0;
      end
    end
    $display("op reset abort y=%h expected=00000000", y);
    last_y = 32'h0;
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 32'h0, 32'h0);

    for (int i = 0; i < 50; i++) begin
      logic [31:0] a, b;
      a = gen_operand();
      b = gen_operand();
      run_op(a, b, ref_div(a, b), (i % 7 == 3) ? 9 : 0, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
